// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Write-side master for the core register file. Merges ALU results
//   (fixed priority, never stalled) with memory-load results into the file's
//   single write port. Load results are buffered in a small FIFO. A buffered
//   load that an ALU result overwrites is squashed in place.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   alu_valid/addres/data      ALU result, always accepted
//   mem_valid/ready/addres/data load result with valid/ready handshake
//   signal_we/addres_write/data_write  registered register-file write port
//   pending_count              occupied FIFO slots, squashed ones included
//   busy                       FIFO non-empty or a write on the port
module regfile_write_arbiter #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned ADDRES     = $clog2(WORD_SIZE),
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              alu_valid,
  input  logic [ADDRES-1:0]                 alu_addres,
  input  logic [WORD_SIZE-1:0]              alu_data,
  input  logic                              mem_valid,
  output logic                              mem_ready,
  input  logic [ADDRES-1:0]                 mem_addres,
  input  logic [WORD_SIZE-1:0]              mem_data,
  output logic                              signal_we,
  output logic [ADDRES-1:0]                 addres_write,
  output logic [WORD_SIZE-1:0]              data_write,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   pending_count,
  output logic                              busy
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] LP_DEPTH = CNT_W'(FIFO_DEPTH);

  // FIFO storage and control
  logic [ADDRES-1:0]    r_addr [FIFO_DEPTH];
  logic [WORD_SIZE-1:0] r_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_vld;
  logic [PTR_W-1:0]     r_head;
  logic [PTR_W-1:0]     r_tail;
  logic [CNT_W-1:0]     r_count;

  // Write port registers
  logic                 r_we;
  logic [ADDRES-1:0]    r_waddr;
  logic [WORD_SIZE-1:0] r_wdata;

  logic                  w_empty;
  logic                  w_alu_wr;
  logic                  w_mem_acc;
  logic                  w_mem_drop;
  logic                  w_pop;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_head_vld;
  logic [FIFO_DEPTH-1:0] w_squash;

  // Handshake: ready comes only from the registered count, never from mem_valid
  assign mem_ready = rst_n & (r_count < LP_DEPTH);

  assign w_empty    = (r_count == '0);
  assign w_alu_wr   = alu_valid & (alu_addres != '0);
  assign w_mem_acc  = mem_valid & mem_ready;
  assign w_head_vld = r_vld[r_head];

  // Beats to r0, or to the register the ALU writes this same cycle, are
  // consumed and thrown away: the ALU value is younger and wins.
  assign w_mem_drop = w_mem_acc &
                      ((mem_addres == '0) | (w_alu_wr & (mem_addres == alu_addres)));

  // Write selection: ALU first, then FIFO head, then direct bypass
  assign w_pop    = ~w_alu_wr & ~w_empty;
  assign w_bypass = ~w_alu_wr & w_empty & w_mem_acc & (mem_addres != '0);
  assign w_push   = w_mem_acc & ~w_mem_drop & ~w_bypass;

  // Entries older than an ALU write to the same register become dead
  always_comb begin
    w_squash = '0;
    for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
      w_squash[i] = w_alu_wr & r_vld[i] & (r_addr[i] == alu_addres);
    end
  end

  // FIFO control: pointers, occupancy and per-entry valid bits.
  // The pushed slot is never the popped head (push implies count < depth,
  // and pop implies count > 0), so the ordering of the updates is safe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        if (w_squash[i]) begin
          r_vld[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + PTR_W'(1);
      end
      if (w_push) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO payload; contents are meaningless while the valid bit is clear
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= mem_addres;
      r_data[r_tail] <= mem_data;
    end
  end

  // Registered write port; address and data hold when no write is issued
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_alu_wr) begin
        r_we    <= 1'b1;
        r_waddr <= alu_addres;
        r_wdata <= alu_data;
      end else if (w_pop) begin
        // A squashed head is retired as a bubble
        if (w_head_vld) begin
          r_we    <= 1'b1;
          r_waddr <= r_addr[r_head];
          r_wdata <= r_data[r_head];
        end
      end else if (w_bypass) begin
        r_we    <= 1'b1;
        r_waddr <= mem_addres;
        r_wdata <= mem_data;
      end
    end
  end

  assign signal_we     = r_we;
  assign addres_write  = r_waddr;
  assign data_write    = r_wdata;
  assign pending_count = r_count;
  assign busy          = ~w_empty | r_we;

endmodule
